mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requester channels (1..8).
REQ-002 SHALL have parameter ADDR_BITS, default 32, block address width.
REQ-003 SHALL have parameter BLOCK_BITS, default 256, data block width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_en  input  NCH  per-channel read request, level, held until rsp_ready.
REQ-007 SHALL have port req_we  input  NCH  per-channel write request, level, held until rsp_ready.
REQ-008 SHALL have port req_addr  input  NCH*ADDR_BITS  packed addresses, channel i at [i*ADDR_BITS +: ADDR_BITS].
REQ-009 SHALL have port req_wdata  input  NCH*BLOCK_BITS  packed write blocks, same packing.
REQ-010 SHALL have port rsp_rdata  output  BLOCK_BITS  registered read block, shared by all channels.
REQ-011 SHALL have port rsp_ready  output  NCH  one-cycle completion pulse, one-hot.
REQ-012 SHALL have port mem_addr / mem_wdata  output  ADDR_BITS / BLOCK_BITS  downstream address and write block.
REQ-013 SHALL have port mem_en / mem_we  output  1 / 1  downstream read / write request.
REQ-014 SHALL have port mem_rdata  input  BLOCK_BITS  downstream read block.
REQ-015 SHALL have port mem_ready  input  1  downstream completion pulse.
REQ-016 SHALL have port mem_accR / mem_accW  input  1 / 1  downstream read / write accept.
REQ-017 SHALL have port flush / flushed  input / output  1 / 1  drain request / drained indication.
REQ-018 SHALL have port grant_id  output  clog2(NCH) (min 1)  channel currently owning the port.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one transaction outstanding at a time.
REQ-020 In IDLE with flush low, a channel SHALL be pending when req_en[i] or req_we[i] is high and no rsp_ready pulse to it occurs that cycle.
REQ-021 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NCH; first pending channel wins; last_grant updates on grant.
REQ-022 On grant SHALL register channel, address, write block and op (write if req_we[i], else read) and enter ISSUE next cycle.
REQ-023 Channel with req_en and req_we both high SHALL be served as write; read is re-arbitrated as a fresh request afterwards.
REQ-024 In ISSUE SHALL hold mem_en (read) or mem_we (write) high with registered mem_addr/mem_wdata until mem_accR (read) / mem_accW (write) is high, then drop it and enter WAIT.
REQ-025 In WAIT SHALL hold mem_en/mem_we low; on mem_ready SHALL capture mem_rdata into rsp_rdata (reads only) and enter RESP.
REQ-026 mem_ready coinciding with accept SHALL enter RESP directly, skipping WAIT.
REQ-027 In RESP SHALL pulse rsp_ready[grant] for exactly one cycle, then return to IDLE; minimum grant-to-rsp_ready latency 3 cycles.
REQ-028 rsp_rdata SHALL hold its value until the next read completion; unchanged by writes.
REQ-029 mem_en and mem_we SHALL never be high in the same cycle.
REQ-030 Requests SHALL not be cancellable; deasserting req_* after grant SHALL not abort the transaction.
REQ-031 flush high SHALL block new grants; active transaction completes normally.
REQ-032 flushed SHALL be high exactly when flush is high and FSM is IDLE; low otherwise.
REQ-033 grant_id SHALL show the registered grant channel in ISSUE/WAIT/RESP and last_grant in IDLE.
REQ-034 NCH=1 SHALL degenerate to pass-through with the same FSM and latency.

Reset
REQ-035 reset low SHALL immediately force IDLE, mem_en=0, mem_we=0, rsp_ready=0, flushed=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, last_grant=NCH-1, grant_id=NCH-1.
REQ-036 Reset mid-transaction SHALL abandon it with no rsp_ready pulse; first grant after release goes to the lowest pending channel.

Verification
REQ-037 NCH=2, ch0 read 0x100, mem_accR next cycle, mem_ready 2 cycles later with 0xA5..A5 -> rsp_ready=01 one cycle, rsp_rdata=0xA5..A5.
REQ-038 ch0 and ch1 request reads continuously -> grants alternate 0,1,0,1; each rsp_ready one-hot, never overlapping.
REQ-039 ch1 req_en and req_we both high, addr 0x40 -> write issued first (mem_we=1, mem_en=0), then read to 0x40; two rsp_ready[1] pulses.
REQ-040 flush raised during WAIT of ch0 read -> transaction completes, flushed=1 the cycle after RESP, pending ch1 not granted until flush drops.
REQ-041 mem_accR withheld 5 cycles -> mem_en held high 6 cycles with stable mem_addr; deasserts the cycle after accept.
REQ-042 reset asserted in WAIT -> all outputs zero immediately, no rsp_ready; after release, ch0 and ch1 pending -> ch0 granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory port among NCH requester
// channels, with one transaction outstanding at a time and a flush/drain handshake.
module mem_port_arbiter #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned ADDR_BITS  = 32,
    parameter int unsigned BLOCK_BITS = 256,
    localparam int unsigned GW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCH-1:0]            req_en,
    input  logic [NCH-1:0]            req_we,
    input  logic [NCH*ADDR_BITS-1:0]  req_addr,
    input  logic [NCH*BLOCK_BITS-1:0] req_wdata,
    output logic [BLOCK_BITS-1:0]     rsp_rdata,
    output logic [NCH-1:0]            rsp_ready,
    output logic [ADDR_BITS-1:0]      mem_addr,
    output logic [BLOCK_BITS-1:0]     mem_wdata,
    output logic                      mem_en,
    output logic                      mem_we,
    input  logic [BLOCK_BITS-1:0]     mem_rdata,
    input  logic                      mem_ready,
    input  logic                      mem_accR,
    input  logic                      mem_accW,
    input  logic                      flush,
    output logic                      flushed,
    output logic [GW-1:0]             grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } stateT;

    stateT                 state;
    logic [GW-1:0]         lastGrant;
    logic                  curWrite;
    logic [NCH-1:0]        pending;
    logic                  found;
    logic [GW-1:0]         nextCh;
    int unsigned           idx;
    logic [ADDR_BITS-1:0]  selAddr;
    logic [BLOCK_BITS-1:0] selWdata;
    logic                  selWrite;
    logic                  accepted;
    logic [NCH-1:0]        grantOneHot;

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        pending = (req_en | req_we) & ~rsp_ready;
        found   = 1'b0;
        nextCh  = lastGrant;
        idx     = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (32'(lastGrant) + k + 1) % NCH;
            if (!found && pending[idx]) begin
                found  = 1'b1;
                nextCh = GW'(idx);
            end
        end
    end

    always_comb begin
        selAddr     = req_addr[32'(nextCh)*ADDR_BITS +: ADDR_BITS];
        selWdata    = req_wdata[32'(nextCh)*BLOCK_BITS +: BLOCK_BITS];
        selWrite    = req_we[nextCh];
        accepted    = curWrite ? mem_accW : mem_accR;
        grantOneHot = NCH'(1) << lastGrant;
    end

    // The registered grant always equals lastGrant, so one register serves both.
    assign grant_id = lastGrant;
    assign flushed  = reset & flush & (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lastGrant <= GW'(NCH - 1);
            curWrite  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_ready <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && found) begin
                        lastGrant <= nextCh;
                        mem_addr  <= selAddr;
                        mem_wdata <= selWdata;
                        curWrite  <= selWrite;
                        mem_en    <= !selWrite;
                        mem_we    <= selWrite;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accepted) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (mem_ready) begin
                            if (!curWrite) begin
                                rsp_rdata <= mem_rdata;
                            end
                            rsp_ready <= grantOneHot;
                            state     <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (!curWrite) begin
                            rsp_rdata <= mem_rdata;
                        end
                        rsp_ready <= grantOneHot;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_ready <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
